pwm_fade_sequencer: RTL and testbench
=====================================

Name: pwm_fade_sequencer

Overview:
- Multi-channel brightness controller that generates the 8-bit duty values fed to a bank of 8-bit PWM generators.
- Accepts fade commands over a valid/ready interface.
- Ramps each channel's duty toward its commanded target, one LSB per programmable number of PWM periods.
- Signals completion per channel.
- Sits between the control logic (input decode/user interface) and the PWM instances.

Parameters:
- NUM_CH, 4, number of duty channels (1..16).
- CH_W, 2, width of cmd_ch; must be >= ceil(log2(NUM_CH)), minimum 1.
- PERIOD, 255, PWM period in clk cycles (matches the 0..254 PWM count); legal range 2..65535.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global run enable; low freezes all sequencing.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_ch  input  CH_W  target channel index.
- cmd_target  input  8  final duty value, 0..255.
- cmd_rate  input  8  PWM periods per 1-LSB step; 0 = jump immediately.
- duty_out  output  8*NUM_CH  per-channel duty value; channel k occupies bits [8k+7:8k].
- busy  output  NUM_CH  channel is ramping.
- done  output  NUM_CH  one-cycle pulse when a channel reaches its target.
- period_tick  output  1  one-cycle pulse on the last cycle of each PWM period.

Behaviour:
- Reset (async, any time, including mid-ramp): duty_out all 0; busy 0; done 0; period_tick 0; period counter 0; all rate counters 0; all channels IDLE. Reset state holds until reset deasserts.
- cmd_ready = enable && !reset, combinational. A handshake occurs when cmd_valid && cmd_ready is sampled on a rising edge.
- Period counter: counts 0..PERIOD-1 while enable=1, wraps to 0. period_tick is registered and high in the cycle the counter equals PERIOD-1.
- Per-channel FSM has two states, IDLE and RAMP. Each channel holds target[7:0], rate[7:0] and rate counter rc[7:0].
- Command accept on channel c (effects visible on the edge that samples the handshake):
  - cmd_rate=0, or cmd_target==duty[c]: duty[c] <= cmd_target; state IDLE; done[c] pulses; busy[c]=0.
  - Otherwise: target <= cmd_target; rate <= cmd_rate; rc <= 0; state RAMP; busy[c]=1. duty is unchanged, so a ramp continues from the current value.
- Command to a channel in RAMP: retargets it. Same rules as above; rc is cleared, and no done is issued for the abandoned target.
- cmd_ch >= NUM_CH: handshake completes, command is discarded, no output changes.
- RAMP step: on each edge where period_tick=1:
  - if rc == rate-1: rc <= 0, and duty moves 1 toward target (+1 if duty < target, -1 if duty > target);
  - otherwise rc <= rc+1.
  - First step occurs exactly cmd_rate ticks after accept.
- Arithmetic never wraps: duty saturates at the target. 0->255 takes exactly 255 steps; 255->0 likewise.
- Arrival: the edge that writes duty==target also sets state IDLE, clears busy[c] and sets done[c] for exactly one cycle.
- Command and period_tick on the same edge for the same channel: the command wins, and that tick is ignored for that channel. Other channels step normally.
- Multiple channels may complete on the same edge; each has an independent done bit.
- enable=0: period counter, rc, duty, states and busy all hold. period_tick=0; done=0 after the current pulse ends; no commands are accepted. Operation resumes from the held state when enable returns to 1.
- duty_out, busy, done and period_tick are all registered; no combinational path from command inputs to outputs.

Test Plan:
- Reset then idle (PERIOD=4) -> duty_out=0, busy=0, done=0; period_tick pulses every 4 cycles.
- Cmd ch0 target=5 rate=1 from duty 0 -> busy[0]=1; duty 1,2,3,4,5 on successive period_ticks; done[0] single pulse with duty=5; busy[0]=0 on that same edge.
- Cmd ch1 target=200 rate=0 -> duty1=200 on the next edge, done[1] pulse, busy[1] never set. Then cmd ch1 target=197 rate=2 -> step every 2nd tick: 199,198,197, then done.
- Ramp ch2 0->10 rate=1; at duty=4 issue target=2 coincident with period_tick -> no step on that tick; descends 3,2; exactly one done (for target 2).
- Mid-ramp: enable=0 for 20 cycles -> duty, busy and period counter frozen, cmd_ready=0. Assert reset mid-ramp -> all outputs 0 immediately.
- Cmd ch0 and ch3 with equal distance and rate -> done[0] and done[3] pulse on the same cycle. Cmd with cmd_ch=5 (NUM_CH=4) -> accepted, no effect.

Source files
------------

// File: rtl/pwm_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_fade_sequencer
//  Description : Multi-channel duty sequencer for a bank of 8-bit PWM
//                generators. Accepts fade commands over valid/ready and
//                ramps each channel's duty one LSB per 'rate' PWM periods
//                toward its target, pulsing 'done' on arrival.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock
//    reset        in   asynchronous, active-high reset
//    enable       in   global run enable; low freezes all sequencing
//    cmd_valid    in   command present
//    cmd_ready    out  command can be accepted this cycle (enable && !reset)
//    cmd_ch       in   target channel index (out-of-range is discarded)
//    cmd_target   in   final duty value
//    cmd_rate     in   PWM periods per 1-LSB step; 0 = jump immediately
//    duty_out     out  channel k duty on bits [8k+7:8k]
//    busy         out  per-channel ramp in progress
//    done         out  per-channel one-cycle arrival pulse
//    period_tick  out  one-cycle pulse on the last cycle of each PWM period
// ============================================================================
module pwm_fade_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int PERIOD = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CH_W-1:0]     cmd_ch,
    input  logic [7:0]          cmd_target,
    input  logic [7:0]          cmd_rate,
    output logic [8*NUM_CH-1:0] duty_out,
    output logic [NUM_CH-1:0]   busy,
    output logic [NUM_CH-1:0]   done,
    output logic                period_tick
);

    localparam logic [15:0] c_last = 16'(PERIOD - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // PWM period counter and registered end-of-period tick
    // ------------------------------------------------------------------------
    logic [15:0] r_pcnt;
    logic        r_tick;
    logic [15:0] w_pcnt_next;

    assign cmd_ready   = enable && !reset;
    assign w_pcnt_next = (r_pcnt == c_last) ? 16'd0 : r_pcnt + 16'd1;

    // The tick is computed from the next count so that it is high exactly
    // while the counter sits at PERIOD-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt <= 16'd0;
            r_tick <= 1'b0;
        end else if (!enable) begin
            r_tick <= 1'b0;
        end else begin
            r_pcnt <= w_pcnt_next;
            r_tick <= (w_pcnt_next == c_last);
        end
    end

    assign period_tick = r_tick;

    // ------------------------------------------------------------------------
    // Per-channel ramp engines
    // ------------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            localparam logic [CH_W-1:0] c_idx = CH_W'(k);

            state_t     r_state;
            logic [7:0] r_duty;
            logic [7:0] r_tgt;
            logic [7:0] r_rate;
            logic [7:0] r_rc;
            logic       r_busy;
            logic       r_done;

            logic       w_hit;
            logic       w_jump;
            logic       w_rc_wrap;
            logic [7:0] w_duty_step;

            assign w_hit     = cmd_valid && enable && (cmd_ch == c_idx);
            assign w_jump    = (cmd_rate == 8'd0) || (cmd_target == r_duty);
            assign w_rc_wrap = (r_rc == r_rate - 8'd1);
            // In RAMP duty never equals target, so the step direction is
            // unambiguous and the result cannot overshoot or wrap.
            assign w_duty_step = (r_duty < r_tgt) ? r_duty + 8'd1
                                                  : r_duty - 8'd1;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                    r_duty  <= 8'd0;
                    r_tgt   <= 8'd0;
                    r_rate  <= 8'd0;
                    r_rc    <= 8'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end else if (!enable) begin
                    r_done <= 1'b0;
                end else begin
                    r_done <= 1'b0;
                    // A command takes priority over a coincident tick; the
                    // tick is simply not applied to this channel.
                    if (w_hit) begin
                        r_tgt <= cmd_target;
                        r_rc  <= 8'd0;
                        if (w_jump) begin
                            r_duty  <= cmd_target;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_rate  <= cmd_rate;
                            r_state <= ST_RAMP;
                            r_busy  <= 1'b1;
                        end
                    end else if (r_state == ST_RAMP && r_tick) begin
                        if (w_rc_wrap) begin
                            r_rc   <= 8'd0;
                            r_duty <= w_duty_step;
                            if (w_duty_step == r_tgt) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_rc <= r_rc + 8'd1;
                        end
                    end
                end
            end

            assign duty_out[8*k +: 8] = r_duty;
            assign busy[k]            = r_busy;
            assign done[k]            = r_done;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_fade_sequencer
//  Description : Self-checking bench for pwm_fade_sequencer (4 channels,
//                PWM period of 4 clocks). A command table is replayed and
//                hand-written sequences cover retarget-on-tick, enable
//                freeze, mid-ramp reset and simultaneous completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_sequencer;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 3;
    localparam int PERIOD = 4;

    logic                clk        = 1'b0;
    logic                reset      = 1'b1;
    logic                enable     = 1'b1;
    logic                cmd_valid  = 1'b0;
    logic [CH_W-1:0]     cmd_ch     = '0;
    logic [7:0]          cmd_target = '0;
    logic [7:0]          cmd_rate   = '0;
    logic                cmd_ready;
    logic [8*NUM_CH-1:0] duty_out;
    logic [NUM_CH-1:0]   busy;
    logic [NUM_CH-1:0]   done;
    logic                period_tick;

    pwm_fade_sequencer #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .PERIOD (PERIOD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_target  (cmd_target),
        .cmd_rate    (cmd_rate),
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: each channel remembers where a ramp started, where it
    // is going, its rate and how many period ticks it has seen since accept.
    // The expected duty is start +/- min(ticks/rate, distance).
    // ------------------------------------------------------------------------
    int m_from  [NUM_CH];
    int m_to    [NUM_CH];
    int m_rate  [NUM_CH];
    int m_ticks [NUM_CH];
    bit m_ramp  [NUM_CH];
    bit m_jdone [NUM_CH];

    typedef struct {
        int ch;
        int tgt;
    } sb_t;
    sb_t sb[$];

    function automatic int mduty(input int k);
        int d;
        int moved;
        if (!m_ramp[k]) return m_from[k];
        d     = (m_to[k] > m_from[k]) ? m_to[k] - m_from[k] : m_from[k] - m_to[k];
        moved = m_ticks[k] / m_rate[k];
        if (moved > d) moved = d;
        return (m_to[k] > m_from[k]) ? m_from[k] + moved : m_from[k] - moved;
    endfunction

    // Outputs are compared on the falling edge; inputs seen here are the ones
    // the next rising edge will sample.
    always @(negedge clk) begin : mon
        int  ed;
        bit  arr;
        int  idx;
        int  c;
        int  cur;
        sb_t e;
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_from[k]  = 0;
                m_to[k]    = 0;
                m_rate[k]  = 1;
                m_ticks[k] = 0;
                m_ramp[k]  = 1'b0;
                m_jdone[k] = 1'b0;
            end
            sb.delete();
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                ed  = mduty(k);
                arr = m_ramp[k] && (ed == m_to[k]);
                chk($sformatf("duty[%0d]", k), int'(duty_out[8*k +: 8]), ed);
                chk($sformatf("busy[%0d]", k), int'(busy[k]), int'(m_ramp[k] && !arr));
                chk($sformatf("done[%0d]", k), int'(done[k]), int'(arr || m_jdone[k]));
                if (done[k]) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (idx < 0 && sb[i].ch == k) idx = i;
                    chk($sformatf("sb_entry[%0d]", k), int'(idx >= 0), 1);
                    if (idx >= 0) begin
                        chk($sformatf("sb_duty[%0d]", k), int'(duty_out[8*k +: 8]), sb[idx].tgt);
                        sb.delete(idx);
                    end
                end
                if (arr) begin
                    m_from[k] = m_to[k];
                    m_ramp[k] = 1'b0;
                end
                m_jdone[k] = 1'b0;
            end
            c = -1;
            if (cmd_valid && enable && int'(cmd_ch) < NUM_CH) begin
                c   = int'(cmd_ch);
                cur = mduty(c);
                // An abandoned target will never produce a done.
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].ch == c) sb.delete(i);
                e.ch  = c;
                e.tgt = int'(cmd_target);
                sb.push_back(e);
                if (cmd_rate == 8'd0 || int'(cmd_target) == cur) begin
                    m_from[c]  = int'(cmd_target);
                    m_ramp[c]  = 1'b0;
                    m_jdone[c] = 1'b1;
                end else begin
                    m_from[c]  = cur;
                    m_to[c]    = int'(cmd_target);
                    m_rate[c]  = int'(cmd_rate);
                    m_ticks[c] = 0;
                    m_ramp[c]  = 1'b1;
                end
            end
            if (period_tick && enable)
                for (int k = 0; k < NUM_CH; k++)
                    if (k != c && m_ramp[k]) m_ticks[k]++;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int tgt, input int rate);
        cmd_valid  = 1'b1;
        cmd_ch     = ch[CH_W-1:0];
        cmd_target = tgt[7:0];
        cmd_rate   = rate[7:0];
        step();
        cmd_valid  = 1'b0;
    endtask

    // Counts period ticks consumed after the accept edge until done[ch].
    task automatic wait_done(input int ch, output int ticks, output bit ok);
        ticks = 0;
        ok    = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done[ch]) begin
                ok = 1'b1;
                break;
            end
            if (period_tick) ticks++;
            step();
        end
    endtask

    function automatic int duty_of(input int ch);
        return int'(duty_out[8*ch +: 8]);
    endfunction

    typedef struct {
        int ch;
        int tgt;
        int rate;
        int exp_ticks;
    } vec_t;

    initial begin : main
        vec_t vecs[8];
        int   ticks;
        bit   ok;
        int   first;
        int   second;
        int   n;

        //            ch  tgt rate ticks-to-arrival
        vecs[0] = '{0,   5,  1,   5};
        vecs[1] = '{1, 200,  0,   0};
        vecs[2] = '{1, 197,  2,   6};
        vecs[3] = '{3,   3,  3,   9};
        vecs[4] = '{0,   5,  4,   0};
        vecs[5] = '{0,   2,  1,   3};
        vecs[6] = '{2, 255,  1, 255};
        vecs[7] = '{2,   0,  1, 255};

        // Reset state
        #12;
        chk("rst_duty",  int'(duty_out),    0);
        chk("rst_busy",  int'(busy),        0);
        chk("rst_done",  int'(done),        0);
        chk("rst_tick",  int'(period_tick), 0);
        chk("rst_ready", int'(cmd_ready),   0);
        step();
        reset = 1'b0;

        // Period tick cadence from a fresh counter
        first  = -1;
        second = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (period_tick) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        chk("tick_first",   first,          3);
        chk("tick_spacing", second - first, PERIOD);

        // Command table
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].ch, vecs[i].tgt, vecs[i].rate);
            chk($sformatf("v%0d_busy", i), int'(busy[vecs[i].ch]), int'(vecs[i].exp_ticks != 0));
            wait_done(vecs[i].ch, ticks, ok);
            chk($sformatf("v%0d_arrived", i), int'(ok), 1);
            chk($sformatf("v%0d_ticks", i), ticks, vecs[i].exp_ticks);
            chk($sformatf("v%0d_duty", i), duty_of(vecs[i].ch), vecs[i].tgt);
            step();
        end

        // Retarget coincident with a period tick
        send(2, 10, 1);
        n = 0;
        while (duty_of(2) != 4 && n < 200) begin
            step();
            n++;
        end
        chk("b_reach4", duty_of(2), 4);
        n = 0;
        while (!period_tick && n < 10) begin
            step();
            n++;
        end
        chk("b_tick_sync", int'(period_tick), 1);
        send(2, 2, 1);
        chk("b_no_step", duty_of(2), 4);
        chk("b_busy", int'(busy[2]), 1);
        wait_done(2, ticks, ok);
        chk("b_arrived", int'(ok), 1);
        chk("b_ticks", ticks, 2);
        chk("b_final", duty_of(2), 2);

        // Enable freeze mid-ramp
        send(0, 50, 1);
        repeat (5) step();
        n = 0;
        while (!period_tick && n < 10) begin
            step();
            n++;
        end
        step();
        step();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("c_ready_low", int'(cmd_ready),   0);
            chk("c_tick_low",  int'(period_tick), 0);
        end
        chk("c_busy_held", int'(busy[0]), 1);
        enable = 1'b1;
        n = 0;
        while (!period_tick && n < 10) begin
            step();
            n++;
        end
        chk("c_resume_phase", n, 2);

        // Asynchronous reset mid-ramp
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        chk("d_duty",  int'(duty_out),    0);
        chk("d_busy",  int'(busy),        0);
        chk("d_done",  int'(done),        0);
        chk("d_tick",  int'(period_tick), 0);
        chk("d_ready", int'(cmd_ready),   0);
        step();
        reset = 1'b0;
        step();
        chk("d_post_duty", int'(duty_out), 0);

        // Two channels finishing together
        n = 0;
        while (!period_tick && n < 10) begin
            step();
            n++;
        end
        step();
        send(0, 3, 2);
        send(3, 3, 2);
        wait_done(0, ticks, ok);
        chk("e_arrived", int'(ok), 1);
        chk("e_ticks", ticks, 6);
        chk("e_done_pair", int'(done), 9);
        step();

        // Out-of-range channel is accepted and ignored
        cmd_valid  = 1'b1;
        cmd_ch     = 3'd5;
        cmd_target = 8'd77;
        cmd_rate   = 8'd0;
        #1;
        chk("f_ready", int'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        chk("f_duty", int'(duty_out), 32'h0300_0003);
        chk("f_done", int'(done), 0);
        step();
        chk("f_busy", int'(busy), 0);

        repeat (2) step();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
